// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates one single-ported shared data memory between the
//               CPU 32-bit system bus and the GEMM accelerator 128-bit line
//               interface.
//               - CPU accesses are single-cycle word transfers. They are
//                 granted combinationally in the same cycle as the request.
//               - Accelerator accesses are uninterruptible line bursts of
//                 1..16 beats.
//               - A streak counter limits how many consecutive CPU grants
//                 may occur while a burst request is waiting.
// Ports       : clk, rst_n           - clock, async active-low reset
//               cpu_*  (in)           - CPU word request, address, mask, data
//               cpu_ready/rd_*        - CPU accept strobe, read return
//               acc_*  (in)           - burst request, line addr, length, data
//               acc_gnt/done          - burst accept / completion pulses
//               acc_wr_ready/rd_*     - per-beat write consume / read return
//               mem_*                 - unified line port towards the memory
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int CPU_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    // CPU system bus
    input  logic         cpu_req,
    input  logic         cpu_rdwr,
    input  logic [31:0]  cpu_addr,
    input  logic [3:0]   cpu_mask,
    input  logic [31:0]  cpu_wr_data,
    output logic         cpu_ready,
    output logic [31:0]  cpu_rd_data,
    output logic         cpu_rd_valid,
    // Accelerator line interface
    input  logic         acc_req,
    input  logic         acc_rdwr,
    input  logic [31:0]  acc_addr,
    input  logic [3:0]   acc_len,
    output logic         acc_gnt,
    input  logic [127:0] acc_wr_data,
    output logic         acc_wr_ready,
    output logic [127:0] acc_rd_data,
    output logic         acc_rd_valid,
    output logic         acc_done,
    // Memory line port
    output logic         mem_en,
    output logic         mem_rdwr,
    output logic [31:0]  mem_addr,
    output logic [15:0]  mem_mask,
    output logic [127:0] mem_wr_data,
    input  logic [127:0] mem_rd_data
);

    localparam int STREAK_W = $clog2(CPU_MAX + 1);

    localparam logic [0:0]          c_IDLE       = 1'b0;
    localparam logic [0:0]          c_BURST      = 1'b1;
    localparam logic [STREAK_W-1:0] c_STREAK_MAX = STREAK_W'(CPU_MAX);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]          r_state;
    logic [STREAK_W-1:0] r_streak;
    logic [31:0]         r_base;
    logic                r_wr;
    logic [4:0]          r_beats;      // 1..16
    logic [4:0]          r_beat;       // index of the beat issued this cycle
    logic                r_cpu_rd_pend;
    logic                r_acc_rd_pend;
    logic [1:0]          r_lane;
    logic                r_done;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic        w_idle;
    logic        w_burst;
    logic        w_cpu_win;
    logic        w_acc_win;
    logic        w_last_beat;
    logic [1:0]  w_lane;
    logic [3:0]  w_cpu_mask4;
    logic [15:0] w_cpu_mask16;
    logic [31:0] w_burst_addr;
    logic        w_unused;

    assign w_idle  = (r_state == c_IDLE);
    assign w_burst = (r_state == c_BURST);

    // The CPU wins unless a burst is waiting and the CPU has already used
    // up its allowance of consecutive grants.
    assign w_cpu_win = w_idle && cpu_req && (!acc_req || (r_streak < c_STREAK_MAX));
    assign w_acc_win = w_idle && !w_cpu_win && acc_req;

    assign w_last_beat = w_burst && (r_beat == (r_beats - 5'd1));

    assign w_lane       = cpu_addr[3:2];
    // Reads fetch the whole word lane; writes use the byte enables.
    assign w_cpu_mask4  = cpu_rdwr ? cpu_mask : 4'hF;
    assign w_cpu_mask16 = {12'h000, w_cpu_mask4} << {w_lane, 2'b00};

    // Beat address: base + 16*beat, wrapping modulo 2^32.
    assign w_burst_addr = r_base + {23'd0, r_beat, 4'h0};

    // Sub-line address bits carry no information for this port.
    assign w_unused = ^{cpu_addr[1:0], acc_addr[3:0]};

    // ------------------------------------------------------------------
    // Combinational grant / memory strobe. Gated by rst_n so that every
    // output drops to zero the moment reset asserts, without waiting for
    // a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        cpu_ready    = 1'b0;
        acc_gnt      = 1'b0;
        acc_wr_ready = 1'b0;
        mem_en       = 1'b0;
        mem_rdwr     = 1'b0;
        mem_addr     = 32'h0;
        mem_mask     = 16'h0;
        mem_wr_data  = 128'h0;
        if (rst_n) begin
            if (w_burst) begin
                mem_en   = 1'b1;
                mem_rdwr = r_wr;
                mem_addr = w_burst_addr;
                mem_mask = 16'hFFFF;
                if (r_wr) begin
                    acc_wr_ready = 1'b1;
                    mem_wr_data  = acc_wr_data;
                end
            end else if (w_cpu_win) begin
                cpu_ready   = 1'b1;
                mem_en      = 1'b1;
                mem_rdwr    = cpu_rdwr;
                mem_addr    = {cpu_addr[31:4], 4'h0};
                mem_mask    = w_cpu_mask16;
                mem_wr_data = {4{cpu_wr_data}};
            end else if (w_acc_win) begin
                acc_gnt = 1'b1;
            end
        end
    end

    // Read return: the tag registered with the strobe picks the consumer.
    assign cpu_rd_valid = r_cpu_rd_pend;
    assign cpu_rd_data  = r_cpu_rd_pend ? mem_rd_data[{r_lane, 5'b00000} +: 32] : 32'h0;
    assign acc_rd_valid = r_acc_rd_pend;
    assign acc_rd_data  = r_acc_rd_pend ? mem_rd_data : 128'h0;
    assign acc_done     = r_done;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_streak      <= '0;
            r_base        <= 32'h0;
            r_wr          <= 1'b0;
            r_beats       <= 5'd0;
            r_beat        <= 5'd0;
            r_cpu_rd_pend <= 1'b0;
            r_acc_rd_pend <= 1'b0;
            r_lane        <= 2'b00;
            r_done        <= 1'b0;
        end else begin
            r_cpu_rd_pend <= w_cpu_win && !cpu_rdwr;
            r_acc_rd_pend <= w_burst && !r_wr;
            // Done lines up with the return of the final read beat.
            r_done        <= w_last_beat;

            if (w_cpu_win) begin
                r_lane <= w_lane;
            end

            // A CPU grant with a burst waiting implies streak < CPU_MAX,
            // so the increment saturates at CPU_MAX by construction.
            if (w_cpu_win) begin
                r_streak <= acc_req ? (r_streak + STREAK_W'(1)) : '0;
            end else if (w_acc_win) begin
                r_streak <= '0;
            end

            if (w_idle) begin
                if (w_acc_win) begin
                    r_state <= c_BURST;
                    r_base  <= {acc_addr[31:4], 4'h0};
                    r_wr    <= acc_rdwr;
                    r_beats <= (acc_len == 4'd0) ? 5'd16 : {1'b0, acc_len};
                    r_beat  <= 5'd0;
                end
            end else begin
                r_beat <= r_beat + 5'd1;
                if (w_last_beat) begin
                    r_state <= c_IDLE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A table of CPU word
//               accesses, hand-written burst / contention / reset sequences,
//               then randomized traffic. A transaction-level reference model
//               with its own shadow memory predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int CPU_MAX = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req = 1'b0, cpu_rdwr = 1'b0;
    logic [31:0]  cpu_addr = '0, cpu_wr_data = '0;
    logic [3:0]   cpu_mask = '0;
    logic         cpu_ready, cpu_rd_valid;
    logic [31:0]  cpu_rd_data;
    logic         acc_req = 1'b0, acc_rdwr = 1'b0;
    logic [31:0]  acc_addr = '0;
    logic [3:0]   acc_len = '0;
    logic [127:0] acc_wr_data = '0;
    logic         acc_gnt, acc_wr_ready, acc_rd_valid, acc_done;
    logic [127:0] acc_rd_data;
    logic         mem_en, mem_rdwr;
    logic [31:0]  mem_addr;
    logic [15:0]  mem_mask;
    logic [127:0] mem_wr_data;
    logic [127:0] mem_rd_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.CPU_MAX(CPU_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_rdwr(cpu_rdwr), .cpu_addr(cpu_addr),
        .cpu_mask(cpu_mask), .cpu_wr_data(cpu_wr_data), .cpu_ready(cpu_ready),
        .cpu_rd_data(cpu_rd_data), .cpu_rd_valid(cpu_rd_valid),
        .acc_req(acc_req), .acc_rdwr(acc_rdwr), .acc_addr(acc_addr),
        .acc_len(acc_len), .acc_gnt(acc_gnt), .acc_wr_data(acc_wr_data),
        .acc_wr_ready(acc_wr_ready), .acc_rd_data(acc_rd_data),
        .acc_rd_valid(acc_rd_valid), .acc_done(acc_done),
        .mem_en(mem_en), .mem_rdwr(mem_rdwr), .mem_addr(mem_addr),
        .mem_mask(mem_mask), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] data,
                                           input logic [15:0] mask);
        logic [127:0] r;
        r = old;
        for (int b = 0; b < 16; b++) if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Memory environment: 256 lines, addressed by bits [11:4]; one-cycle
    // read latency.
    // ------------------------------------------------------------------
    logic [127:0] mem [256];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_rdwr) mem[mem_addr[11:4]] <= merge(mem[mem_addr[11:4]], mem_wr_data, mem_mask);
            else          mem_rd_data <= mem[mem_addr[11:4]];
        end
    end

    // ------------------------------------------------------------------
    // Reference model: beats remaining, streak as an integer, shadow
    // memory updated from the model's own decisions.
    // ------------------------------------------------------------------
    logic [127:0] shadow [256];
    int           m_left = 0, m_i = 0, m_streak = 0;
    logic [31:0]  m_base = '0;
    logic         m_wr = 1'b0;
    logic         p_cpu_rv = 0, p_acc_rv = 0, p_done = 0;
    logic [31:0]  p_cpu_rd = '0;
    logic [127:0] p_acc_rd = '0;

    always @(negedge clk) begin : model
        logic         e_cpu_ready, e_gnt, e_en, e_rdwr, e_wrdy;
        logic [31:0]  e_addr;
        logic [15:0]  e_mask;
        logic [127:0] e_wdata, ln;
        logic         n_cpu_rv, n_acc_rv, n_done;
        logic [31:0]  n_cpu_rd;
        logic [127:0] n_acc_rd;
        int           lane;
        e_cpu_ready = 0; e_gnt = 0; e_en = 0; e_rdwr = 0; e_wrdy = 0;
        e_addr = '0; e_mask = '0; e_wdata = '0;
        n_cpu_rv = 0; n_acc_rv = 0; n_done = 0; n_cpu_rd = '0; n_acc_rd = '0;
        if (!rst_n) begin
            m_left = 0; m_streak = 0;
            p_cpu_rv = 0; p_acc_rv = 0; p_done = 0;
        end else if (m_left > 0) begin
            e_en = 1; e_mask = 16'hFFFF; e_rdwr = m_wr; e_wrdy = m_wr;
            e_addr = m_base + 32'(16 * m_i);
            if (m_wr) begin
                e_wdata = acc_wr_data;
                shadow[e_addr[11:4]] = acc_wr_data;
            end else begin
                n_acc_rv = 1;
                n_acc_rd = shadow[e_addr[11:4]];
            end
            m_i++;
            m_left--;
            if (m_left == 0) n_done = 1;
        end else if (cpu_req && (!acc_req || m_streak < CPU_MAX)) begin
            lane = int'(cpu_addr[3:2]);
            e_cpu_ready = 1; e_en = 1; e_rdwr = cpu_rdwr;
            e_addr = {cpu_addr[31:4], 4'h0};
            e_mask = 16'(cpu_rdwr ? cpu_mask : 4'hF) << (4 * lane);
            e_wdata = {4{cpu_wr_data}};
            ln = shadow[e_addr[11:4]];
            if (cpu_rdwr) begin
                for (int b = 0; b < 4; b++)
                    if (cpu_mask[b]) ln[32*lane + 8*b +: 8] = cpu_wr_data[8*b +: 8];
                shadow[e_addr[11:4]] = ln;
            end else begin
                n_cpu_rv = 1;
                n_cpu_rd = ln[32*lane +: 32];
            end
            m_streak = acc_req ? m_streak + 1 : 0;
        end else if (acc_req) begin
            e_gnt = 1;
            m_left = (acc_len == 0) ? 16 : int'(acc_len);
            m_i = 0;
            m_base = {acc_addr[31:4], 4'h0};
            m_wr = acc_rdwr;
            m_streak = 0;
        end
        chk("m_cpu_ready", cpu_ready, e_cpu_ready);
        chk("m_acc_gnt", acc_gnt, e_gnt);
        chk("m_mem_en", mem_en, e_en);
        chk("m_mem_rdwr", mem_rdwr, e_rdwr);
        chk("m_mem_addr", mem_addr, e_addr);
        chk("m_mem_mask", mem_mask, e_mask);
        chk("m_acc_wr_ready", acc_wr_ready, e_wrdy);
        if (e_en && e_rdwr) chk("m_mem_wr_data", mem_wr_data, e_wdata);
        chk("m_cpu_rd_valid", cpu_rd_valid, p_cpu_rv);
        if (p_cpu_rv) chk("m_cpu_rd_data", cpu_rd_data, p_cpu_rd);
        chk("m_acc_rd_valid", acc_rd_valid, p_acc_rv);
        if (p_acc_rv) chk("m_acc_rd_data", acc_rd_data, p_acc_rd);
        chk("m_acc_done", acc_done, p_done);
        p_cpu_rv = n_cpu_rv; p_cpu_rd = n_cpu_rd;
        p_acc_rv = n_acc_rv; p_acc_rd = n_acc_rd;
        p_done = n_done;
    end

    // Handshake history for the random driver.
    logic seen_ready = 0, seen_gnt = 0;
    always @(negedge clk) begin
        seen_ready <= cpu_ready;
        seen_gnt   <= acc_gnt;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rdwr;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] e_addr;
        logic [15:0] e_mask;
        logic [31:0] e_rd;
    } cpu_vec_t;

    initial begin : stim
        cpu_vec_t    tbl[7];
        logic [63:0] pat;
        logic [7:0]  ch;
        logic        g;
        int          cnt;
        logic [31:0] last;

        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end

        //         rdwr  addr           mask  wdata          e_addr         e_mask    e_rd
        tbl[0] = '{1'b1, 32'h0000_0104, 4'hF, 32'hDEADBEEF, 32'h0000_0100, 16'h00F0, 32'h0};
        tbl[1] = '{1'b0, 32'h0000_0104, 4'h0, 32'h0,        32'h0000_0100, 16'h00F0, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 32'h0000_010B, 4'h5, 32'h11223344, 32'h0000_0100, 16'h0500, 32'h0};
        tbl[3] = '{1'b0, 32'h0000_0108, 4'h0, 32'h0,        32'h0000_0100, 16'h0F00, 32'h00220044};
        tbl[4] = '{1'b1, 32'hFFFF_FFFC, 4'h8, 32'hAABBCCDD, 32'hFFFF_FFF0, 16'h8000, 32'h0};
        tbl[5] = '{1'b0, 32'hFFFF_FFFF, 4'h0, 32'h0,        32'hFFFF_FFF0, 16'hF000, 32'hAA000000};
        tbl[6] = '{1'b0, 32'h0000_0100, 4'h0, 32'h0,        32'h0000_0100, 16'h000F, 32'h0};

        // --- Reset: requests present, everything must stay zero ---
        cpu_req = 1; acc_req = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_acc_gnt", acc_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_mask", mem_mask, 0);
        chk("rst_rd_valids", {cpu_rd_valid, acc_rd_valid, acc_done}, 0);
        tick();
        cpu_req = 0; acc_req = 0; rst_n = 1;

        // --- Table of CPU word accesses ---
        for (int i = 0; i < 7; i++) begin
            tick();
            cpu_req = 1; cpu_rdwr = tbl[i].rdwr; cpu_addr = tbl[i].addr;
            cpu_mask = tbl[i].mask; cpu_wr_data = tbl[i].wdata;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), cpu_ready, 1);
            chk($sformatf("tbl%0d_en", i), {mem_en, mem_rdwr}, {1'b1, tbl[i].rdwr});
            chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_mask", i), mem_mask, tbl[i].e_mask);
            if (tbl[i].rdwr) chk($sformatf("tbl%0d_wdata", i), mem_wr_data, {4{tbl[i].wdata}});
            tick();
            cpu_req = 0;
            @(negedge clk);
            chk($sformatf("tbl%0d_rd_valid", i), cpu_rd_valid, !tbl[i].rdwr);
            if (!tbl[i].rdwr) chk($sformatf("tbl%0d_rd_data", i), cpu_rd_data, tbl[i].e_rd);
        end

        // --- Accelerator write burst of 4 at 0x200, data k = {4{k}} ---
        tick();
        acc_req = 1; acc_rdwr = 1; acc_addr = 32'h200; acc_len = 4;
        @(negedge clk);
        chk("wb_gnt", {acc_gnt, mem_en}, 2'b10);
        for (int k = 1; k <= 4; k++) begin
            tick();
            acc_req = 0; acc_wr_data = {4{32'(k)}};
            @(negedge clk);
            chk($sformatf("wb%0d_ready", k), {acc_wr_ready, mem_en, mem_rdwr, acc_done}, 4'b1110);
            chk($sformatf("wb%0d_addr", k), mem_addr, 32'h200 + 32'(16 * (k - 1)));
            chk($sformatf("wb%0d_mask", k), mem_mask, 16'hFFFF);
            chk($sformatf("wb%0d_data", k), mem_wr_data, {4{32'(k)}});
        end
        tick();
        @(negedge clk);
        chk("wb_done", {acc_done, acc_wr_ready}, 2'b10);

        // --- Accelerator read burst of 4 at 0x200 ---
        tick();
        acc_req = 1; acc_rdwr = 0; acc_addr = 32'h20C; acc_len = 4;
        @(negedge clk);
        chk("rb_gnt", acc_gnt, 1);
        for (int i = 0; i <= 4; i++) begin
            tick();
            acc_req = 0;
            @(negedge clk);
            if (i < 4) chk($sformatf("rb%0d_addr", i), {mem_en, mem_rdwr, mem_addr}, {2'b10, 32'h200 + 32'(16 * i)});
            else       chk("rb_idle_en", mem_en, 0);
            chk($sformatf("rb%0d_valid", i), acc_rd_valid, i > 0);
            if (i > 0) chk($sformatf("rb%0d_data", i), acc_rd_data, {4{32'(i)}});
            chk($sformatf("rb%0d_done", i), acc_done, i == 4);
        end

        // --- acc_len = 0: sixteen beats, last at base + 0xF0 ---
        tick();
        acc_req = 1; acc_rdwr = 0; acc_addr = 32'h300; acc_len = 0;
        cnt = 0; last = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_en) begin
                cnt++;
                last = mem_addr;
            end
            g = acc_gnt;
            tick();
            if (g) acc_req = 0;
        end
        chk("len0_beats", cnt, 16);
        chk("len0_last_addr", last, 32'h3F0);

        // --- Contention: both held; CPU x4, gnt, 2 beats, CPU ---
        cpu_req = 1; cpu_rdwr = 0; cpu_addr = 32'h104;
        acc_req = 1; acc_rdwr = 0; acc_addr = 32'h200; acc_len = 2;
        pat = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            ch = cpu_ready ? "C" : acc_gnt ? "G" : mem_en ? "B" : "-";
            pat = {pat[55:0], ch};
            if (c == 7) chk("cont_done_overlap", {acc_done, acc_rd_valid}, 2'b11);
            g = acc_gnt;
            tick();
            if (g) acc_req = 0;
        end
        chk("cont_pattern", pat, "CCCCGBBC");
        cpu_req = 0;

        // --- Reset during beat 3 of an 8-beat read ---
        tick();
        acc_req = 1; acc_rdwr = 0; acc_addr = 32'h200; acc_len = 8;
        @(negedge clk);
        chk("rr_gnt", acc_gnt, 1);
        for (int b = 1; b <= 3; b++) begin
            tick();
            acc_req = 0;
            @(negedge clk);
            chk($sformatf("rr_beat%0d_addr", b), mem_addr, 32'h200 + 32'(16 * (b - 1)));
        end
        #2 rst_n = 0;
        #1;
        chk("rr_zero_now", {mem_en, acc_rd_valid, acc_done, cpu_ready, acc_gnt, mem_addr}, 0);
        @(posedge clk); #2;
        @(posedge clk); #2 rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rr_quiet%0d", c), {acc_done, acc_rd_valid, mem_en}, 0);
        end
        tick();
        cpu_req = 1; cpu_rdwr = 0; cpu_addr = 32'h104;
        @(negedge clk);
        chk("rr_cpu_ready", cpu_ready, 1);
        tick();
        cpu_req = 0; acc_req = 1; acc_rdwr = 0; acc_addr = 32'h200; acc_len = 1;
        @(negedge clk);
        chk("rr_acc_gnt", acc_gnt, 1);
        chk("rr_cpu_rd", {cpu_rd_valid, cpu_rd_data}, {1'b1, 32'hDEADBEEF});
        tick();
        acc_req = 0;
        @(negedge clk);
        chk("rr_beat_addr", {mem_en, mem_addr}, {1'b1, 32'h200});
        tick();
        @(negedge clk);
        chk("rr_done", {acc_done, acc_rd_valid}, 2'b11);
        chk("rr_data", acc_rd_data, {4{32'd1}});

        // --- Randomized traffic against the reference model ---
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!cpu_req || seen_ready) begin
                cpu_req     = ($urandom_range(0, 99) < 50);
                cpu_rdwr    = 1'($urandom_range(0, 1));
                cpu_addr    = {($urandom_range(0, 7) == 0) ? 20'hFFFFF : 20'h00000, 12'($urandom)};
                cpu_mask    = 4'($urandom);
                cpu_wr_data = $urandom;
            end
            if (!acc_req || seen_gnt) begin
                acc_req  = ($urandom_range(0, 99) < 15);
                acc_rdwr = 1'($urandom_range(0, 1));
                acc_addr = {($urandom_range(0, 7) == 0) ? 20'hFFFFF : 20'h00000, 12'($urandom)};
                acc_len  = 4'($urandom);
            end
            acc_wr_data = {$urandom, $urandom, $urandom, $urandom};
        end
        tick();
        cpu_req = 0; acc_req = 0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("drain_idle", {mem_en, acc_done, acc_rd_valid, cpu_rd_valid}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-ported shared data memory between the RISC-V core's 32-bit system bus and the GEMM accelerator's 128-bit line interface. CPU accesses are single-cycle word transfers. Accelerator accesses are uninterruptible line bursts of 1–16 beats. A starvation counter keeps either side from being locked out. The block sits between the core/accelerator and the memory's unified line port.

## Interface
- CPU_MAX, 4: consecutive CPU grants allowed while an accelerator request is pending.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request
- cpu_rdwr  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address; bits [1:0] ignored
- cpu_mask  in  4  byte enables for writes
- cpu_wr_data  in  32  write word
- cpu_ready  out  1  access accepted this cycle; CPU holds request until high
- cpu_rd_data  out  32  read word
- cpu_rd_valid  out  1  read data valid
- acc_req  in  1  burst request; held until acc_gnt
- acc_rdwr  in  1  1 = write burst
- acc_addr  in  32  line address; bits [3:0] ignored
- acc_len  in  4  beat count; 0 means 16
- acc_gnt  out  1  burst accepted (1-cycle pulse)
- acc_wr_data  in  128  write beat data
- acc_wr_ready  out  1  write beat consumed this cycle
- acc_rd_data  out  128  read beat data
- acc_rd_valid  out  1  read beat valid
- acc_done  out  1  burst complete (1-cycle pulse)
- mem_en, mem_rdwr  out  1 each  memory strobe, 1 = write
- mem_addr  out  32  line-aligned address
- mem_mask  out  16  byte enables
- mem_wr_data  out  128  write line
- mem_rd_data  in  128  read line, valid 1 cycle after a read strobe

## Operation
- FSM states: IDLE, BURST. `streak` counter is 0..CPU_MAX (saturating).
- IDLE, CPU wins when `cpu_req && (!acc_req || streak < CPU_MAX)`:
  - cpu_ready=1 and mem_en=1 in the same cycle (combinational grant).
  - mem_addr = {cpu_addr[31:4], 4'b0}.
  - lane = cpu_addr[3:2]; mem_mask = (rdwr ? cpu_mask : 4'hF) << 4*lane.
  - mem_wr_data = cpu_wr_data replicated to all 4 lanes.
  - streak increments if acc_req is high, else clears.
- IDLE, otherwise if acc_req:
  - acc_gnt=1; no memory access this cycle.
  - Latch addr, rdwr, and beats = (acc_len==0 ? 16 : acc_len).
  - Clear streak; go to BURST.
- BURST: one beat per cycle, mem_en=1, mem_mask=16'hFFFF, mem_addr = base + 16*i for i = 0..beats-1.
  - Write beat: acc_wr_ready=1, mem_wr_data=acc_wr_data.
  - CPU is stalled (cpu_ready=0) for the whole burst.
  - After the last beat is issued, return to IDLE.
- Read return: the registered source tag and lane select the destination.
  - CPU read: cpu_rd_data = mem_rd_data lane `lane`.
  - Accelerator read: acc_rd_data = mem_rd_data.
- Address arithmetic wraps modulo 2^32.
- Idle outputs: mem_* = 0, all handshake outputs = 0.

## Timing
- Reset (asynchronous, any state): FSM → IDLE, streak=0, all outputs 0, latched tag cleared.
  - A burst in progress is aborted, with no acc_done and no pending rd_valid.
- CPU read: strobe in cycle T, cpu_rd_valid in T+1. CPU write: no response beyond cpu_ready.
- Burst: acc_gnt at T; beats issue at T+1..T+N.
  - Read beat at cycle t gives acc_rd_valid at t+1.
  - acc_done is asserted at T+N+1, the same cycle as the last read's acc_rd_valid.
- Back-to-back CPU accesses: one per cycle; read data pipelines at one per cycle.
- Simultaneous cpu_req and acc_req in IDLE: CPU wins while streak < CPU_MAX, else the burst wins.
- After a burst, a pending CPU request is served in the IDLE cycle at T+N+1, since streak=0.
  - A new burst can start no earlier than T+N+1.
- The IDLE cycle after a burst may overlap acc_done / the last acc_rd_valid.

## Test plan
- CPU write 0xDEADBEEF, mask 4'b1111, to 0x104; then read 0x104.
  - Write: mem_mask = 16'h00F0.
  - Read: cpu_rd_valid one cycle after cpu_ready, cpu_rd_data = 0xDEADBEEF.
- Accelerator write burst, acc_len=4, addr 0x200, data k = {4{k}}; then read burst of 4.
  - Write: wr_ready on four consecutive cycles at 0x200/0x210/0x220/0x230.
  - Read: four acc_rd_valid beats returning the same data; acc_done coincides with beat 4.
- acc_len=0: 16 beats issued; last mem_addr = base + 0xF0.
- cpu_req and acc_req held high together, CPU_MAX=4.
  - Required pattern: 4 CPU grants, acc_gnt, burst, then a CPU grant in the first IDLE cycle after the burst.
- cpu_req asserted mid-burst: cpu_ready stays 0 until the IDLE cycle after the last beat.
- rst_n pulsed low during beat 3 of an 8-beat read.
  - Outputs go 0 immediately.
  - No acc_done or further rd_valid.
  - The next request is granted normally.
